// File: rtl/gemm_accelerator.sv
// Output-stationary int8 GEMM engine: a 4x16 MAC tile accumulates one C tile per pass
// over K, streaming A/B words from SRAM and writing the finished tile as one C word.
module gemm_accelerator #(
  parameter int InDataWidth   = 8,
  parameter int RowPar        = 4,
  parameter int ColPar        = 16,
  parameter int AccWidth      = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [SizeAddrWidth-1:0]            M_size_i,
  input  logic [SizeAddrWidth-1:0]            K_size_i,
  input  logic [SizeAddrWidth-1:0]            N_size_i,
  output logic [AddrWidth-1:0]                sram_a_addr_o,
  input  logic [RowPar*InDataWidth-1:0]       sram_a_rdata_i,
  output logic [AddrWidth-1:0]                sram_b_addr_o,
  input  logic [ColPar*InDataWidth-1:0]       sram_b_rdata_i,
  output logic [AddrWidth-1:0]                sram_c_addr_o,
  output logic [RowPar*ColPar*AccWidth-1:0]   sram_c_wdata_o,
  output logic                                sram_c_we_o,
  output logic                                done_o,
  output logic [2:0]                          dbg_state
);

  localparam int ProdWidth = 2 * InDataWidth;
  localparam int RowShift  = $clog2(RowPar);
  localparam int ColShift  = $clog2(ColPar);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    LAST   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SizeAddrWidth-1:0] m_blocks_q, n_blocks_q, k_size_q;
  logic [SizeAddrWidth-1:0] k_cnt_q, mb_cnt_q, nb_cnt_q;
  logic [AddrWidth-1:0]     a_base_q, b_base_q, c_addr_q;
  logic                     acc_valid_q, acc_first_q;
  logic [RowPar*ColPar*AccWidth-1:0] acc_q, acc_d;

  logic [SizeAddrWidth-1:0] m_blocks_in, n_blocks_in;
  logic                     zero_job, last_issue, nb_wrap, last_tile;
  logic signed [ProdWidth-1:0] prod;
  logic [AccWidth-1:0]         prod_ext;

  // Partial blocks are truncated: only whole 4-row / 16-column blocks are computed.
  assign m_blocks_in = M_size_i >> RowShift;
  assign n_blocks_in = N_size_i >> ColShift;
  assign zero_job    = (m_blocks_in == '0) || (n_blocks_in == '0) || (K_size_i == '0);

  assign last_issue = (k_cnt_q == k_size_q - 1'b1);
  assign nb_wrap    = (nb_cnt_q == n_blocks_q - 1'b1);
  assign last_tile  = nb_wrap && (mb_cnt_q == m_blocks_q - 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = zero_job ? FINISH : RUN;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_d = LAST;
        end
      end
      LAST:    state_d = WRITE;
      WRITE:   state_d = last_tile ? FINISH : RUN;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Base addresses track mb*K and nb*K incrementally so no multiplier is needed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_blocks_q <= '0;
      n_blocks_q <= '0;
      k_size_q   <= '0;
      k_cnt_q    <= '0;
      mb_cnt_q   <= '0;
      nb_cnt_q   <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            m_blocks_q <= m_blocks_in;
            n_blocks_q <= n_blocks_in;
            k_size_q   <= K_size_i;
            k_cnt_q    <= '0;
            mb_cnt_q   <= '0;
            nb_cnt_q   <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_addr_q   <= '0;
          end
        end
        RUN: begin
          k_cnt_q <= k_cnt_q + 1'b1;
        end
        WRITE: begin
          k_cnt_q  <= '0;
          c_addr_q <= c_addr_q + 1'b1;
          if (nb_wrap) begin
            nb_cnt_q <= '0;
            mb_cnt_q <= mb_cnt_q + 1'b1;
            a_base_q <= a_base_q + k_size_q[AddrWidth-1:0];
            b_base_q <= '0;
          end else begin
            nb_cnt_q <= nb_cnt_q + 1'b1;
            b_base_q <= b_base_q + k_size_q[AddrWidth-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Read data returns one cycle after the address, so the MAC runs one cycle behind issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_valid_q <= 1'b0;
      acc_first_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      acc_valid_q <= (state_q == RUN);
      acc_first_q <= (state_q == RUN) && (k_cnt_q == '0);
      if (acc_valid_q) begin
        acc_q <= acc_d;
      end
    end
  end

  // The first beat of a tile loads the product instead of adding, replacing a clear cycle.
  always_comb begin
    acc_d    = acc_q;
    prod     = '0;
    prod_ext = '0;
    for (int r = 0; r < RowPar; r++) begin
      for (int c = 0; c < ColPar; c++) begin
        prod = $signed(sram_a_rdata_i[r*InDataWidth +: InDataWidth]) *
               $signed(sram_b_rdata_i[c*InDataWidth +: InDataWidth]);
        prod_ext = {{(AccWidth-ProdWidth){prod[ProdWidth-1]}}, prod};
        if (acc_first_q) begin
          acc_d[(r*ColPar+c)*AccWidth +: AccWidth] = prod_ext;
        end else begin
          acc_d[(r*ColPar+c)*AccWidth +: AccWidth] =
            acc_q[(r*ColPar+c)*AccWidth +: AccWidth] + prod_ext;
        end
      end
    end
  end

  assign sram_a_addr_o  = (state_q == RUN) ? a_base_q + k_cnt_q[AddrWidth-1:0] : '0;
  assign sram_b_addr_o  = (state_q == RUN) ? b_base_q + k_cnt_q[AddrWidth-1:0] : '0;
  assign sram_c_addr_o  = (state_q == WRITE) ? c_addr_q : '0;
  assign sram_c_wdata_o = acc_q;
  assign sram_c_we_o    = (state_q == WRITE);
  assign done_o         = (state_q == FINISH);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_gemm_accelerator.sv
// Self-checking bench for gemm_accelerator: SRAM models, matrix-level reference model,
// a write scoreboard and scenario tasks for tiling, signed extremes, reset and back-to-back jobs.
module tb_gemm_accelerator;

  localparam int AW = 12;
  localparam int CW = 2048;

  logic          clk, rst_n, start;
  logic [31:0]   m_size, k_size, n_size;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [31:0]   a_rdata;
  logic [127:0]  b_rdata;
  logic [CW-1:0] c_wdata;
  logic          c_we, done;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [31:0]  mem_a [4096];
  logic [127:0] mem_b [4096];
  int a_mat [8][64];
  int b_mat [64][32];

  // Scoreboard: expected C words in write order, with their address and cycle.
  logic [CW-1:0] exp_q[$];
  int exp_addr_q[$];
  int exp_cyc_q[$];
  int wr_cnt = 0;
  int overlap = 0;
  bit done_seen = 0;
  int done_cyc = -1;

  gemm_accelerator dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .M_size_i       (m_size),
    .K_size_i       (k_size),
    .N_size_i       (n_size),
    .sram_a_addr_o  (a_addr),
    .sram_a_rdata_i (a_rdata),
    .sram_b_addr_o  (b_addr),
    .sram_b_rdata_i (b_rdata),
    .sram_c_addr_o  (c_addr),
    .sram_c_wdata_o (c_wdata),
    .sram_c_we_o    (c_we),
    .done_o         (done),
    .dbg_state      (dbg_state)
  );

  // Clock, cycle counter and one-cycle-latency SRAM read ports.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  task automatic scoreboard();
    logic [CW-1:0] exp_w;
    int ea, ec, bad;
    forever begin
      @(negedge clk);
      if (c_we === 1'b1 && done === 1'b1) overlap++;
      if (c_we === 1'b1) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d at cycle %0d, expected no write", c_addr, cyc - start_cyc);
        end else begin
          exp_w = exp_q.pop_front();
          ea = exp_addr_q.pop_front();
          ec = exp_cyc_q.pop_front();
          checks++;
          if (c_addr !== ea[AW-1:0]) begin
            errors++;
            $display("FAIL c_addr: got %0d expected %0d", c_addr, ea);
          end
          checks++;
          if ((cyc - start_cyc) !== ec) begin
            errors++;
            $display("FAIL c_write_cycle: addr %0d got cycle %0d expected %0d", ea, cyc - start_cyc, ec);
          end
          bad = -1;
          for (int e = 0; e < 64; e++) begin
            if (bad < 0 && c_wdata[e*32 +: 32] !== exp_w[e*32 +: 32]) bad = e;
          end
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL c_data: addr %0d elem %0d got %0d expected %0d", ea, bad,
                     $signed(c_wdata[bad*32 +: 32]), $signed(exp_w[bad*32 +: 32]));
          end
        end
      end
      if (done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc = cyc - start_cyc;
      end
    end
  endtask

  // Reference model: lay matrices out in SRAM and compute C with plain integer sums.
  task automatic rand_mats();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 64; k++) a_mat[i][k] = int'($urandom_range(255)) - 128;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 32; j++) b_mat[k][j] = int'($urandom_range(255)) - 128;
  endtask

  task automatic fill_mats(input int av, input int bv);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 64; k++) a_mat[i][k] = av;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 32; j++) b_mat[k][j] = bv;
  endtask

  task automatic build_expected(input int m, input int k, input int n,
                                output int exp_done, output int exp_writes);
    int mbn, nbn, s, t;
    logic [31:0]   wa;
    logic [127:0]  wb;
    logic [CW-1:0] wc;
    mbn = m / 4;
    nbn = n / 16;
    exp_q.delete();
    exp_addr_q.delete();
    exp_cyc_q.delete();
    for (int mb = 0; mb < mbn; mb++)
      for (int kk = 0; kk < k; kk++) begin
        for (int r = 0; r < 4; r++) wa[8*r +: 8] = 8'(a_mat[4*mb+r][kk]);
        mem_a[mb*k + kk] = wa;
      end
    for (int nb = 0; nb < nbn; nb++)
      for (int kk = 0; kk < k; kk++) begin
        for (int c = 0; c < 16; c++) wb[8*c +: 8] = 8'(b_mat[kk][16*nb+c]);
        mem_b[nb*k + kk] = wb;
      end
    t = 0;
    if (k > 0) begin
      for (int mb = 0; mb < mbn; mb++)
        for (int nb = 0; nb < nbn; nb++) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) begin
              s = 0;
              for (int kk = 0; kk < k; kk++) s += a_mat[4*mb+r][kk] * b_mat[kk][16*nb+c];
              wc[(16*r+c)*32 +: 32] = s;
            end
          exp_q.push_back(wc);
          exp_addr_q.push_back(mb*nbn + nb);
          exp_cyc_q.push_back(t*(k+2) + k + 1);
          t++;
        end
    end
    exp_writes = t;
    exp_done = (mbn * nbn * k == 0) ? 0 : mbn * nbn * (k + 2);
  endtask

  // Driver tasks.
  task automatic start_job(input int m, input int k, input int n);
    @(negedge clk);
    m_size = m;
    k_size = k;
    n_size = n;
    start = 1'b1;
    done_seen = 1'b0;
    done_cyc = -1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    m_size = $urandom;
    k_size = $urandom;
    n_size = $urandom;
  endtask

  task automatic wait_done(input int budget, input int poke);
    int i;
    i = 0;
    while (!done_seen && i < budget) begin
      @(negedge clk);
      start = (i == poke);
      if (i == poke) begin
        m_size = $urandom_range(4, 64);
        k_size = $urandom_range(1, 64);
        n_size = $urandom_range(16, 64);
      end
      #1;
      i++;
    end
    start = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic run_job(input int m, input int k, input int n, input int poke,
                         output int exp_done, output int exp_writes);
    build_expected(m, k, n, exp_done, exp_writes);
    wr_cnt = 0;
    start_job(m, k, n);
    wait_done(exp_done + 30, poke);
  endtask

  // Scenario tasks.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_addr !== '0) begin errors++; $display("FAIL reset_a_addr: got %0d expected 0", a_addr); end
    checks++; if (b_addr !== '0) begin errors++; $display("FAIL reset_b_addr: got %0d expected 0", b_addr); end
    checks++; if (c_addr !== '0) begin errors++; $display("FAIL reset_c_addr: got %0d expected 0", c_addr); end
    checks++; if (c_we !== 1'b0) begin errors++; $display("FAIL reset_c_we: got %b expected 0", c_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (c_wdata !== '0) begin errors++; $display("FAIL reset_c_wdata: got nonzero expected 0"); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_tile();
    int ed, ew;
    rand_mats();
    run_job(4, 64, 16, -1, ed, ew);
    checks++; if (done_cyc !== 66) begin errors++; $display("FAIL single_done_cycle: got %0d expected 66", done_cyc); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL single_write_count: got %0d expected 1", wr_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_missing_writes: %0d expected writes not seen", exp_q.size()); end
  endtask

  task automatic test_signed_extremes();
    int ed, ew;
    int bv [2];
    bv[0] = -128;
    bv[1] = 127;
    for (int i = 0; i < 2; i++) begin
      fill_mats(-128, bv[i]);
      run_job(4, 64, 16, -1, ed, ew);
      checks++; if (done_cyc !== ed) begin errors++; $display("FAIL extreme_done_cycle: got %0d expected %0d", done_cyc, ed); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL extreme_write_count: got %0d expected 1", wr_cnt); end
    end
  endtask

  task automatic test_multi_tile();
    int ed, ew;
    int sizes [3][3];
    sizes[0] = '{8, 3, 32};
    sizes[1] = '{10, 5, 40};
    sizes[2] = '{8, int'($urandom_range(1, 12)), 35};
    for (int i = 0; i < 3; i++) begin
      rand_mats();
      run_job(sizes[i][0], sizes[i][1], sizes[i][2], -1, ed, ew);
      checks++; if (done_cyc !== ed) begin errors++; $display("FAIL multi_done_cycle: job %0d got %0d expected %0d", i, done_cyc, ed); end
      checks++; if (wr_cnt !== ew) begin errors++; $display("FAIL multi_write_count: job %0d got %0d expected %0d", i, wr_cnt, ew); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL multi_missing_writes: job %0d %0d not seen", i, exp_q.size()); end
    end
  endtask

  task automatic test_zero_size();
    int ed, ew;
    int sizes [3][3];
    sizes[0] = '{4, 0, 16};
    sizes[1] = '{3, 4, 16};
    sizes[2] = '{4, 4, 15};
    for (int i = 0; i < 3; i++) begin
      rand_mats();
      run_job(sizes[i][0], sizes[i][1], sizes[i][2], -1, ed, ew);
      checks++; if (done_cyc !== 0) begin errors++; $display("FAIL zero_done_cycle: job %0d got %0d expected 0", i, done_cyc); end
      checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL zero_write_count: job %0d got %0d expected 0", i, wr_cnt); end
    end
  endtask

  task automatic test_reset_mid_job();
    int ed, ew;
    rand_mats();
    build_expected(4, 64, 16, ed, ew);
    wr_cnt = 0;
    start_job(4, 64, 16);
    repeat (31) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    exp_cyc_q.delete();
    checks++; if (a_addr !== '0) begin errors++; $display("FAIL midrst_a_addr: got %0d expected 0", a_addr); end
    checks++; if (b_addr !== '0) begin errors++; $display("FAIL midrst_b_addr: got %0d expected 0", b_addr); end
    checks++; if (c_we !== 1'b0) begin errors++; $display("FAIL midrst_c_we: got %b expected 0", c_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (c_wdata !== '0) begin errors++; $display("FAIL midrst_c_wdata: got nonzero expected 0"); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", dbg_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL midrst_write_after_reset: got %0d writes expected 0", wr_cnt); end
    checks++; if (done_seen) begin errors++; $display("FAIL midrst_done_after_reset: got done expected none"); end
    rand_mats();
    run_job(4, 64, 16, -1, ed, ew);
    checks++; if (done_cyc !== ed) begin errors++; $display("FAIL midrst_recover_done: got %0d expected %0d", done_cyc, ed); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL midrst_recover_writes: got %0d expected 1", wr_cnt); end
  endtask

  task automatic test_back_to_back();
    int ed, ew, k, poke;
    for (int j = 0; j < 10; j++) begin
      k = $urandom_range(1, 16);
      poke = $urandom_range(1, k);
      rand_mats();
      run_job(4, k, 16, poke, ed, ew);
      checks++; if (done_cyc !== k + 2) begin errors++; $display("FAIL b2b_done_cycle: job %0d got %0d expected %0d", j, done_cyc, k + 2); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL b2b_write_count: job %0d got %0d expected 1", j, wr_cnt); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_missing_write: job %0d", j); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    m_size = '0;
    k_size = '0;
    n_size = '0;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    fork
      scoreboard();
    join_none
    test_reset();
    test_single_tile();
    test_signed_extremes();
    test_multi_tile();
    test_zero_size();
    test_reset_mid_job();
    test_back_to_back();
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL done_with_write: got %0d overlapping cycles expected 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
